// File: rtl/airlock_sequencer.sv
// Two-door airlock sequencer: arbitrates inner/outer requests, drives door and pump commands,
// and latches a fault on pump/door timeout or a door opening during a pump cycle.
module airlock_sequencer #(
    parameter int unsigned PUMP_TIMEOUT = 16,
    parameter int unsigned DOOR_TIMEOUT = 8,
    parameter int unsigned CNT_W        = 8
) (
    input  logic Clock,
    input  logic Reset,
    input  logic req_inner,
    input  logic req_outer,
    input  logic InnerClosed,
    input  logic OuterClosed,
    input  logic Pressurized,
    input  logic Evacuated,
    output logic open_inner,
    output logic open_outer,
    output logic pump_out,
    output logic pump_in,
    output logic done_inner,
    output logic done_outer,
    output logic busy,
    output logic fault
);

    typedef enum logic [2:0] {
        P_IDLE,
        OPEN_IN,
        EVAC,
        V_IDLE,
        OPEN_OUT,
        PRESS,
        FAULT
    } state_t;

    typedef enum logic {
        SIDE_OUTER,
        SIDE_INNER
    } side_t;

    localparam logic [CNT_W-1:0] PUMP_LIM = CNT_W'(PUMP_TIMEOUT);
    localparam logic [CNT_W-1:0] DOOR_LIM = CNT_W'(DOOR_TIMEOUT);

    state_t           state_q, state_d;
    side_t            last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rel_q, rel_d;
    logic             done_in_ev_q, done_in_ev_d;
    logic             done_out_ev_q, done_out_ev_d;

    logic open_inner_q, open_outer_q, pump_out_q, pump_in_q;
    logic done_inner_q, done_outer_q, busy_q, fault_q;

    logic inner_win, outer_win, doors_closed, pump_to, door_to, cnt_run;

    // A lone request wins; with both pending the side not served last goes first.
    assign inner_win    = req_inner && (!req_outer || (last_q == SIDE_OUTER));
    assign outer_win    = req_outer && (!req_inner || (last_q == SIDE_INNER));
    assign doors_closed = InnerClosed && OuterClosed;
    assign pump_to      = (cnt_q >= PUMP_LIM);
    assign door_to      = (cnt_q >= DOOR_LIM);
    assign cnt_run      = (state_q == EVAC) || (state_q == PRESS) ||
                          (((state_q == OPEN_IN) || (state_q == OPEN_OUT)) && rel_q);

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        rel_d         = rel_q;
        done_in_ev_d  = 1'b0;
        done_out_ev_d = 1'b0;

        case (state_q)
            P_IDLE: begin
                if (inner_win) begin
                    state_d = (Pressurized && OuterClosed) ? OPEN_IN : PRESS;
                end else if (outer_win && doors_closed) begin
                    state_d = EVAC;
                end
            end
            V_IDLE: begin
                if (outer_win) begin
                    state_d = (Evacuated && InnerClosed) ? OPEN_OUT : EVAC;
                end else if (inner_win && doors_closed) begin
                    state_d = PRESS;
                end
            end
            OPEN_IN: begin
                if (!req_inner) rel_d = 1'b1;
                if (rel_q && InnerClosed) begin
                    done_in_ev_d = 1'b1;
                    last_d       = SIDE_INNER;
                    state_d      = P_IDLE;
                end else if (rel_q && door_to) begin
                    state_d = FAULT;
                end
            end
            OPEN_OUT: begin
                if (!req_outer) rel_d = 1'b1;
                if (rel_q && OuterClosed) begin
                    done_out_ev_d = 1'b1;
                    last_d        = SIDE_OUTER;
                    state_d       = V_IDLE;
                end else if (rel_q && door_to) begin
                    state_d = FAULT;
                end
            end
            // EVAC/PRESS are only entered to serve a request, so completion chains
            // directly into the door state while that request is still held.
            EVAC: begin
                if (!doors_closed) begin
                    state_d = FAULT;
                end else if (Evacuated) begin
                    state_d = req_outer ? OPEN_OUT : V_IDLE;
                end else if (pump_to) begin
                    state_d = FAULT;
                end
            end
            PRESS: begin
                if (!doors_closed) begin
                    state_d = FAULT;
                end else if (Pressurized) begin
                    state_d = req_inner ? OPEN_IN : P_IDLE;
                end else if (pump_to) begin
                    state_d = FAULT;
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = FAULT;
        endcase

        if (state_d != state_q) rel_d = 1'b0;

        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_run && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q       <= P_IDLE;
            last_q        <= SIDE_OUTER;
            cnt_q         <= '0;
            rel_q         <= 1'b0;
            done_in_ev_q  <= 1'b0;
            done_out_ev_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            rel_q         <= rel_d;
            done_in_ev_q  <= done_in_ev_d;
            done_out_ev_q <= done_out_ev_d;
        end
    end

    // Registered Moore decode of the current state: commands lag the deciding edge by one cycle.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            open_inner_q <= 1'b0;
            open_outer_q <= 1'b0;
            pump_out_q   <= 1'b0;
            pump_in_q    <= 1'b0;
            done_inner_q <= 1'b0;
            done_outer_q <= 1'b0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            open_inner_q <= (state_q == OPEN_IN) && !rel_q;
            open_outer_q <= (state_q == OPEN_OUT) && !rel_q;
            pump_out_q   <= (state_q == EVAC);
            pump_in_q    <= (state_q == PRESS);
            done_inner_q <= done_in_ev_q;
            done_outer_q <= done_out_ev_q;
            busy_q       <= (state_q != P_IDLE) && (state_q != V_IDLE);
            fault_q      <= (state_q == FAULT);
        end
    end

    assign open_inner = open_inner_q;
    assign open_outer = open_outer_q;
    assign pump_out   = pump_out_q;
    assign pump_in    = pump_in_q;
    assign done_inner = done_inner_q;
    assign done_outer = done_outer_q;
    assign busy       = busy_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_airlock_sequencer.sv
// Directed bench for airlock_sequencer; output vector order is
// {open_inner, open_outer, pump_out, pump_in, done_inner, done_outer, busy, fault}.
module tb_airlock_sequencer;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic req_inner = 1'b0;
    logic req_outer = 1'b0;
    logic InnerClosed = 1'b1;
    logic OuterClosed = 1'b1;
    logic Pressurized = 1'b1;
    logic Evacuated = 1'b0;
    logic open_inner, open_outer, pump_out, pump_in;
    logic done_inner, done_outer, busy, fault;
    logic [7:0] outs;

    int errors = 0;
    int checks = 0;

    localparam logic [7:0] O_IDLE   = 8'b0000_0000;
    localparam logic [7:0] O_OPENI  = 8'b1000_0010;
    localparam logic [7:0] O_OPENO  = 8'b0100_0010;
    localparam logic [7:0] O_PUMPO  = 8'b0010_0010;
    localparam logic [7:0] O_PUMPI  = 8'b0001_0010;
    localparam logic [7:0] O_BUSY   = 8'b0000_0010;
    localparam logic [7:0] O_DONEI  = 8'b0000_1000;
    localparam logic [7:0] O_DONEO  = 8'b0000_0100;
    localparam logic [7:0] O_FAULT  = 8'b0000_0011;

    airlock_sequencer #(
        .PUMP_TIMEOUT(16),
        .DOOR_TIMEOUT(8),
        .CNT_W(8)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .req_inner(req_inner),
        .req_outer(req_outer),
        .InnerClosed(InnerClosed),
        .OuterClosed(OuterClosed),
        .Pressurized(Pressurized),
        .Evacuated(Evacuated),
        .open_inner(open_inner),
        .open_outer(open_outer),
        .pump_out(pump_out),
        .pump_in(pump_in),
        .done_inner(done_inner),
        .done_outer(done_outer),
        .busy(busy),
        .fault(fault)
    );

    always #5 Clock = ~Clock;

    assign outs = {open_inner, open_outer, pump_out, pump_in, done_inner, done_outer, busy, fault};

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    // Mutual-exclusion invariants on every cycle.
    always @(negedge Clock) begin
        checks++;
        assert (!(open_inner && open_outer) && !(pump_in && pump_out)) else begin
            errors++;
            $error("FAIL safety: observed=%b expected=no door/pump conflict", outs);
        end
    end

    initial begin
        // Reset state
        tick(2);
        chk("reset_outs", outs, O_IDLE);
        Reset = 1'b0;

        // Inner service from pressurized idle
        req_inner = 1'b1;
        tick();
        chk("t1_cycle1", outs, O_IDLE);
        tick();
        chk("t1_open_inner", outs, O_OPENI);
        InnerClosed = 1'b0;
        tick();
        req_inner = 1'b0;
        tick();
        chk("t1_open_held", outs, O_OPENI);
        tick();
        chk("t1_released", outs, O_BUSY);
        tick();
        InnerClosed = 1'b1;
        tick();
        chk("t1_closing", outs, O_BUSY);
        tick();
        chk("t1_done_inner", outs, O_DONEI);
        tick();
        chk("t1_done_pulse_end", outs, O_IDLE);

        // Outer service through EVAC, chained straight to OPEN_OUT
        req_outer = 1'b1;
        tick();
        chk("t2_decide", outs, O_IDLE);
        Pressurized = 1'b0;
        tick();
        chk("t2_pump_out", outs, O_PUMPO);
        tick(3);
        Evacuated = 1'b1;
        tick();
        chk("t2_pump_last", outs, O_PUMPO);
        tick();
        chk("t2_open_outer", outs, O_OPENO);
        OuterClosed = 1'b0;
        req_outer = 1'b0;
        tick();
        OuterClosed = 1'b1;
        tick();
        chk("t2_released", outs, O_BUSY);
        tick();
        chk("t2_done_outer", outs, O_DONEO);

        // From vacuum idle, inner request goes through PRESS then chains to OPEN_IN
        req_inner = 1'b1;
        tick();
        chk("t2b_decide", outs, O_IDLE);
        tick();
        chk("t2b_pump_in", outs, O_PUMPI);
        Evacuated = 1'b0;
        Pressurized = 1'b1;
        tick(2);
        chk("t2b_open_inner", outs, O_OPENI);
        req_inner = 1'b0;

        // Both requests after reset: inner first, then outer via EVAC
        do_reset();
        chk("t3_reset", outs, O_IDLE);
        req_inner = 1'b1;
        req_outer = 1'b1;
        tick(2);
        chk("t3_inner_first", outs, O_OPENI);
        InnerClosed = 1'b0;
        req_inner = 1'b0;
        tick();
        InnerClosed = 1'b1;
        tick();
        chk("t3_closing", outs, O_BUSY);
        tick();
        chk("t3_done_inner", outs, O_DONEI);
        tick();
        chk("t3_outer_evac", outs, O_PUMPO);

        // Pump timeout with Evacuated held low (EVAC entered 1 cycle before the check above)
        tick(16);
        chk("t4_pump_at_limit", outs, O_PUMPO);
        tick();
        chk("t4_fault", outs, O_FAULT);
        req_outer = 1'b0;
        req_inner = 1'b1;
        tick(3);
        chk("t4_fault_sticky", outs, O_FAULT);
        req_inner = 1'b0;

        // Door opens during EVAC
        do_reset();
        req_outer = 1'b1;
        tick(2);
        chk("t5a_pump_out", outs, O_PUMPO);
        InnerClosed = 1'b0;
        tick();
        chk("t5a_pump_still", outs, O_PUMPO);
        tick();
        chk("t5a_fault", outs, O_FAULT);
        InnerClosed = 1'b1;
        req_outer = 1'b0;

        // Inner door never recloses after release
        do_reset();
        req_inner = 1'b1;
        tick(2);
        chk("t5b_open_inner", outs, O_OPENI);
        InnerClosed = 1'b0;
        req_inner = 1'b0;
        tick(10);
        chk("t5b_door_at_limit", outs, O_BUSY);
        tick();
        chk("t5b_fault", outs, O_FAULT);
        InnerClosed = 1'b1;

        // Asynchronous reset while pressurizing, then PRESS before OPEN_IN
        do_reset();
        Pressurized = 1'b0;
        req_inner = 1'b1;
        tick(2);
        chk("t6_pump_in", outs, O_PUMPI);
        #3;
        Reset = 1'b1;
        #1;
        chk("t6_async_reset", outs, O_IDLE);
        tick();
        Reset = 1'b0;
        tick(2);
        chk("t6_press_again", outs, O_PUMPI);
        tick();
        Pressurized = 1'b1;
        tick();
        chk("t6_no_early_open", outs, O_PUMPI);
        tick();
        chk("t6_open_inner", outs, O_OPENI);
        InnerClosed = 1'b0;
        req_inner = 1'b0;
        tick();
        InnerClosed = 1'b1;
        tick(2);
        chk("t6_done_inner", outs, O_DONEI);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
